// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    // Owner of the access granted in the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - DMA starvation counter producing a forced-grant flag
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   d_req        DMA request
//   d_gnt        DMA granted this cycle
//   force_grant  registered: DMA must win the next arbitration it requests in
module dmem_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CW       = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_req,
    input  logic d_gnt,
    output logic force_grant
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Counts consecutive denied DMA cycles; any grant or dropped request restarts it.
    always_comb begin
        cnt_next = cnt;
        if (!d_req || d_gnt) begin
            cnt_next = '0;
        end else if (cnt != MAX_CNT) begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            force_grant <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            force_grant <= (cnt_next == MAX_CNT);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA arbiter for a single-port word data memory
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata     core request (held until c_gnt)
//   c_gnt/c_rvalid/c_rdata/c_err  core grant, registered read return, misalign pulse
//   d_*                           same set for the DMA/loader engine
//   mem_we/mem_a/mem_wd           memory write port and address
//   mem_rd                        asynchronous memory read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    logic   force_grant;
    logic   gnt_c;
    logic   gnt_d;
    logic   any_gnt;
    logic   sel_we;
    logic   sel_aligned;
    owner_e owner_q;
    owner_e owner_d;
    logic   rd_q;
    logic   rd_d;
    logic   err_q;
    logic   err_d;

    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_starve (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_req       (d_req),
        .d_gnt       (gnt_d),
        .force_grant (force_grant)
    );

    // Core has priority unless DMA has been starved; nothing is granted in reset.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (rst_n) begin
            if (force_grant && d_req) begin
                gnt_d = 1'b1;
            end else if (c_req) begin
                gnt_c = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end
        end
    end

    assign c_gnt   = gnt_c;
    assign d_gnt   = gnt_d;
    assign any_gnt = gnt_c | gnt_d;

    // Port C drives the memory bus whenever DMA is not the granted port.
    assign mem_a       = gnt_d ? d_addr  : c_addr;
    assign mem_wd      = gnt_d ? d_wdata : c_wdata;
    assign sel_we      = gnt_d ? d_we    : c_we;
    assign sel_aligned = is_aligned(mem_a[1:0]);
    assign mem_we      = any_gnt & sel_we & sel_aligned;

    always_comb begin
        owner_d = OWN_NONE;
        rd_d    = any_gnt & ~sel_we;
        err_d   = any_gnt & ~sel_aligned;
        if (gnt_c) begin
            owner_d = OWN_CORE;
        end else if (gnt_d) begin
            owner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            if (gnt_c && !c_we) begin
                c_rdata <= mem_rd;
            end
            if (gnt_d && !d_we) begin
                d_rdata <= mem_rd;
            end
        end
    end

    // Return pulses are steered by who owned last cycle's access.
    assign c_rvalid = (owner_q == OWN_CORE) & rd_q;
    assign d_rvalid = (owner_q == OWN_DMA)  & rd_q;
    assign c_err    = (owner_q == OWN_CORE) & err_q;
    assign d_err    = (owner_q == OWN_DMA)  & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] ref_mem [64];

    int checks = 0;
    int errors = 0;

    // model state
    logic          e_cg, e_dg, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    logic          m_crv, m_cerr, m_drv, m_derr;
    logic [DW-1:0] m_crd, m_drd;
    int            waited;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = env_mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) env_mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected combinational outputs from the arbitration rules, then compare everything.
    task automatic settle();
        logic forced;
        #1;
        forced = (waited >= MAX_WAIT);
        e_dg = rst_n && d_req && (forced || !c_req);
        e_cg = rst_n && c_req && !e_dg;
        e_a  = e_dg ? d_addr : c_addr;
        e_wd = e_dg ? d_wdata : c_wdata;
        e_we = (e_cg && c_we && c_addr[1:0] == 2'b00) || (e_dg && d_we && d_addr[1:0] == 2'b00);
        chk("c_gnt", 32'(c_gnt), 32'(e_cg));
        chk("d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_a", mem_a, e_a);
        chk("mem_wd", mem_wd, e_wd);
        chk("c_rvalid", 32'(c_rvalid), 32'(m_crv));
        chk("c_rdata", c_rdata, m_crd);
        chk("c_err", 32'(c_err), 32'(m_cerr));
        chk("d_rvalid", 32'(d_rvalid), 32'(m_drv));
        chk("d_rdata", d_rdata, m_drd);
        chk("d_err", 32'(d_err), 32'(m_derr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_crv = 0; m_cerr = 0; m_drv = 0; m_derr = 0;
            m_crd = '0; m_drd = '0; waited = 0;
        end else begin
            m_crv  = e_cg && !c_we;
            m_cerr = e_cg && (c_addr[1:0] != 2'b00);
            m_drv  = e_dg && !d_we;
            m_derr = e_dg && (d_addr[1:0] != 2'b00);
            if (m_crv) m_crd = ref_mem[c_addr[7:2]];
            if (m_drv) m_drd = ref_mem[d_addr[7:2]];
            if (e_we) ref_mem[e_a[7:2]] = e_wd;
            if (!d_req || e_dg) waited = 0;
            else waited = waited + 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'(i) * 32'h01010101;
        end
        env_mem[8'h20 >> 2] = 32'h12345678;
        env_mem[8'h40 >> 2] = 32'hCAFEF00D;
        for (int i = 0; i < 64; i++) ref_mem[i] = env_mem[i];
        m_crv = 0; m_cerr = 0; m_drv = 0; m_derr = 0;
        m_crd = '0; m_drd = '0; waited = 0;

        rst_n = 0;
        c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h1;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h2;
        @(negedge clk);

        // reset hold
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_c_gnt", 32'(c_gnt), 0);
            chk("rst_d_gnt", 32'(d_gnt), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            tick();
        end
        chk("rst_c_rvalid", 32'(c_rvalid), 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // core write then read
        rst_n = 1; d_req = 0;
        c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        settle();
        chk("wr_c_gnt", 32'(c_gnt), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_a", mem_a, 32'h10);
        tick();
        c_we = 0;
        settle();
        chk("rd_c_gnt", 32'(c_gnt), 1);
        tick();
        c_req = 0;
        settle();
        chk("rd_c_rvalid", 32'(c_rvalid), 1);
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        tick();

        // DMA alone reads
        d_req = 1; d_we = 0; d_addr = 32'h20;
        settle();
        chk("dma_d_gnt", 32'(d_gnt), 1);
        tick();
        d_req = 0;
        settle();
        chk("dma_d_rvalid", 32'(d_rvalid), 1);
        chk("dma_d_rdata", d_rdata, 32'h12345678);
        chk("dma_c_rvalid", 32'(c_rvalid), 0);
        tick();

        // continuous contention: 4 core grants then 1 DMA grant
        c_req = 1; c_we = 0; c_addr = 32'h30;
        d_req = 1; d_we = 0; d_addr = 32'h34;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("ratio_d_gnt", 32'(d_gnt), (i % 5 == 4) ? 1 : 0);
            chk("ratio_c_gnt", 32'(c_gnt), (i % 5 == 4) ? 0 : 1);
            tick();
        end
        c_req = 0; d_req = 0;
        settle();
        tick();

        // misaligned core write is suppressed
        c_req = 1; c_we = 1; c_addr = 32'h13; c_wdata = 32'hAAAA5555;
        settle();
        chk("mis_c_gnt", 32'(c_gnt), 1);
        chk("mis_mem_we", 32'(mem_we), 0);
        tick();
        c_we = 0; c_addr = 32'h10;
        settle();
        chk("mis_c_err", 32'(c_err), 1);
        tick();
        c_req = 0;
        settle();
        chk("mis_old_rdata", c_rdata, 32'hDEADBEEF);
        chk("mis_err_clear", 32'(c_err), 0);
        tick();

        // reset during a DMA write
        rst_n = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55;
        settle();
        chk("rstw_d_gnt", 32'(d_gnt), 0);
        chk("rstw_mem_we", 32'(mem_we), 0);
        tick();
        rst_n = 1; d_req = 0;
        settle();
        chk("rstw_d_rvalid", 32'(d_rvalid), 0);
        chk("rstw_d_err", 32'(d_err), 0);
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        c_req = 1; c_we = 0; c_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rstw_ctr_d_gnt", 32'(d_gnt), (i == 4) ? 1 : 0);
            tick();
        end
        c_req = 0; d_req = 0;
        settle();
        chk("rstw_mem_kept", d_rdata, 32'hCAFEF00D);
        tick();

        // randomized traffic following the hold-until-grant handshake
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if (!c_req || e_cg) begin
                c_req   = ($urandom_range(0, 99) < 60);
                c_we    = 1'($urandom_range(0, 1));
                c_addr  = rand_addr();
                c_wdata = $urandom;
            end
            if (!d_req || e_dg) begin
                d_req   = ($urandom_range(0, 99) < 50);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word data memory (one write port, asynchronous read) between two requesters: the core load/store unit (port C) and a DMA/loader engine (port D).
- The core has priority. A starvation counter forces a DMA grant after DMA has waited MAX_WAIT cycles.
- Read data is registered and returned one cycle after grant. Misaligned accesses are flagged and never write memory.
- Sits between the core/DMA and the data memory.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, cycles DMA may be denied while requesting before a forced grant (≥1)
- CW, 3, width of wait counter; must hold MAX_WAIT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (0 = read)
- c_addr  in  AW  core byte address
- c_wdata  in  DW  core write data
- c_gnt  out  1  core granted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DW  core read data
- c_err  out  1  core misaligned-access pulse
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same as the c_* ports, for DMA
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data (asynchronous)

Behaviour:
Reset and clocking:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values: c_rvalid, d_rvalid, c_err, d_err = 0; c_rdata, d_rdata = 0; wait counter = 0; force flag = 0.
- While rst_n = 0, c_gnt, d_gnt and mem_we are forced 0 combinationally.

Grant logic (combinational from req and registered state; at most one grant per cycle):
- force = 1 and d_req: d_gnt = 1.
- Otherwise c_req: c_gnt = 1.
- Otherwise d_req: d_gnt = 1.

Handshake:
- Requester holds req, we, addr and wdata stable until the cycle its gnt = 1. It may drop req only after that grant.
- Each grant is exactly one word access. Back-to-back grants to the same port are allowed.

Memory steering:
- mem_a / mem_wd come from the granted port; they come from port C when no port is granted.
- mem_we = gnt & we & aligned, where aligned = (addr[1:0] == 0). Address is otherwise passed unmodified (sign handling stays in memory).

Read return:
- On the posedge ending a granted read cycle: x_rdata <= mem_rd and x_rvalid <= 1 for the granted port; the other port's rvalid <= 0.
- x_rvalid is a 1-cycle pulse. x_rdata holds its value until the next read to that port.
- Writes produce no rvalid.

Error:
- Granted access with addr[1:0] != 0: x_err pulses 1 on the next cycle (same timing as rvalid).
- A misaligned read still returns mem_rd with rvalid = 1. A misaligned write is suppressed.

Starvation:
- Counter increments when d_req & !d_gnt, saturating at MAX_WAIT.
- Counter clears to 0 when d_gnt, or when !d_req.
- force <= (next counter == MAX_WAIT). DMA therefore wins in the cycle after the counter reaches MAX_WAIT; force clears on that grant.

Boundary cases:
- Simultaneous requests with force = 0: core wins.
- Core request during a forced cycle: core stalls exactly one cycle.
- d_req dropped while force = 1 (protocol violation): force clears, no grant.
- Reset asserted mid-access: the write in that cycle is suppressed, and the pending rvalid/err is not produced.

State encoding:
- last-grant owner register: NONE, CORE, DMA.
- NONE is held after reset and in idle cycles. It drives the rvalid/err steering.

Decomposition:
- Shared package: owner enum (OWN_NONE = 0, OWN_CORE = 1, OWN_DMA = 2); constants for word alignment (ALIGN_MASK = 2'b11).
- One sub-module is natural: dmem_starve_ctr (saturating wait counter + force flag, parameterised by MAX_WAIT/CW).
- Grant mux and return registers stay in the top module.

Test Plan:
1. Reset hold: rst_n = 0 for 3 cycles with c_req = d_req = 1 → all gnt, mem_we, rvalid, err = 0; c_rdata = d_rdata = 0.
2. Core write 0xDEADBEEF to 0x10, then core read 0x10 → cycle 1: c_gnt = 1, mem_we = 1, mem_a = 0x10. Read: c_gnt in cycle 2, c_rvalid = 1 and c_rdata = 0xDEADBEEF in cycle 3.
3. DMA alone reads 0x20 holding 0x12345678 → d_gnt same cycle, d_rvalid = 1 and d_rdata = 0x12345678 next cycle; c_rvalid stays 0.
4. Both request continuously, MAX_WAIT = 4 → c_gnt for 4 cycles, d_gnt on the 5th, then the core resumes; repeating pattern is 4 C : 1 D.
5. Core write to misaligned 0x13 with 0xAAAA5555 → c_gnt = 1, mem_we = 0, c_err = 1 next cycle; a later read of 0x10 returns the old value.
6. Reset asserted in the same cycle as a granted DMA write → no memory write, d_rvalid/d_err stay 0, counter = 0 after release.
